// File: rtl/mtimer.sv
// mtimer: memory-mapped 64-bit machine timer (mtime/mtimecmp) with level interrupt.
// Latency: zero-wait-state reads (data is combinational); writes land on the next posedge; irq_o is registered.
// Backpressure: none; every strobed access completes in the cycle it is presented.
//
// Ports:
//   clk, rst      - single clock, synchronous active-high reset
//   addr          - byte offset in the timer window, bits [4:2] select the word
//   wdata, wr     - write data and direction, qualified by addr_strobe
//   addr_strobe   - access valid this cycle
//   data          - read data, 0 when no read is in progress
//   irq_o         - registered level interrupt: IRQ_EN && (mtime >= mtimecmp)
//
// Optional feature macro: TIMER_PRESCALER_EN (adds the PRESCALE down-counter
// that divides the count rate by PRESCALE+1). Without it mtime counts every
// enabled cycle and PRESCALE reads as zero.
module mtimer #(
    parameter int          PrescaleWidth = 16,
    parameter logic [63:0] CmpResetValue = '1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] data,
    input  logic        wr,
    input  logic        addr_strobe,
    output logic        irq_o
);

    localparam logic [2:0] RegMtimeLo = 3'd0;
    localparam logic [2:0] RegMtimeHi = 3'd1;
    localparam logic [2:0] RegCmpLo   = 3'd2;
    localparam logic [2:0] RegCmpHi   = 3'd3;
    localparam logic [2:0] RegCtrl    = 3'd4;
    localparam logic [2:0] RegPresc   = 3'd5;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [1:0]  ctrl;        // [0] CNT_EN, [1] IRQ_EN
    logic [31:0] hi_shadow;   // MTIME_HI as captured by the last MTIME_LO read
    logic        tick;

    logic [2:0]  word;
    logic        wr_en;
    logic        rd_en;

    assign word  = addr[4:2];
    assign wr_en = addr_strobe && wr;
    assign rd_en = addr_strobe && !wr;

    // Byte-lane bits are not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr[1:0]};

`ifdef TIMER_PRESCALER_EN
    logic [PrescaleWidth-1:0] prescale;
    logic [PrescaleWidth-1:0] psc_cnt;

    assign tick = ctrl[0] && (psc_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale <= '0;
            psc_cnt  <= '0;
        end else if (wr_en && word == RegPresc) begin
            // A new divider value restarts the period immediately.
            prescale <= wdata[PrescaleWidth-1:0];
            psc_cnt  <= wdata[PrescaleWidth-1:0];
        end else if (ctrl[0]) begin
            if (psc_cnt == '0) begin
                psc_cnt <= prescale;
            end else begin
                psc_cnt <= psc_cnt - 1'b1;
            end
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Timer state. A write to either mtime half replaces that half and
    // suppresses the increment for the whole cycle, so no carry crosses
    // into the half that was not written.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime     <= '0;
            mtimecmp  <= CmpResetValue;
            ctrl      <= '0;
            hi_shadow <= '0;
            irq_o     <= 1'b0;
        end else begin
            if (wr_en && word == RegMtimeLo) begin
                mtime[31:0] <= wdata;
            end else if (wr_en && word == RegMtimeHi) begin
                mtime[63:32] <= wdata;
            end else if (ctrl[0] && tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wr_en && word == RegCmpLo) begin
                mtimecmp[31:0] <= wdata;
            end
            if (wr_en && word == RegCmpHi) begin
                mtimecmp[63:32] <= wdata;
            end
            if (wr_en && word == RegCtrl) begin
                ctrl <= wdata[1:0];
            end

            // Snapshot the upper half alongside the LO read so a following
            // HI read pairs with the LO value software already has.
            if (rd_en && word == RegMtimeLo) begin
                hi_shadow <= mtime[63:32];
            end

            irq_o <= ctrl[1] && (mtime >= mtimecmp);
        end
    end

    always_comb begin
        data = '0;
        if (rd_en) begin
            case (word)
                RegMtimeLo: data = mtime[31:0];
                RegMtimeHi: data = hi_shadow;
                RegCmpLo:   data = mtimecmp[31:0];
                RegCmpHi:   data = mtimecmp[63:32];
                RegCtrl:    data = {30'd0, ctrl};
`ifdef TIMER_PRESCALER_EN
                RegPresc:   data = 32'(prescale);
`endif
                default:    data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mtimer.sv
// tb_mtimer: directed self-checking bench for the mtimer block.
// Latency: inputs change on negedge, each register access occupies one clock cycle.
// Backpressure: not applicable; the bench drives one access per cycle.
module tb_mtimer;

    logic        clk;
    logic        rst;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        wr;
    logic        addr_strobe;
    logic        irq_o;

    int checks;
    int errors;

    mtimer dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .wdata       (wdata),
        .data        (data),
        .wr          (wr),
        .addr_strobe (addr_strobe),
        .irq_o       (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end just after a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        addr_strobe = 1'b0;
        wr          = 1'b0;
        addr        = '0;
        wdata       = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        addr        = a;
        wdata       = d;
        wr          = 1'b1;
        addr_strobe = 1'b1;
        @(negedge clk);
        addr_strobe = 1'b0;
        wr          = 1'b0;
    endtask

    task automatic rd_reg(input logic [4:0] a, output logic [31:0] d);
        addr        = a;
        wr          = 1'b0;
        addr_strobe = 1'b1;
        #1 d = data;
        @(negedge clk);
        addr_strobe = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] exp_val [8];
        exp_val = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'h0, 32'h0, 32'h0, 32'h0};
        do_reset();
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", irq_o);
        end
        checks++;
        if (data !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle_data: got %h expected 00000000", data);
        end
        for (int i = 0; i < 8; i++) begin
            rd_reg(5'(i * 4), v);
            checks++;
            if (v !== exp_val[i]) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected %h", i, v, exp_val[i]);
            end
        end
    endtask

    task automatic test_count();
        logic [31:0] v;
        do_reset();
        wr_reg(5'h10, 32'h1);
        idle(10);
        rd_reg(5'h00, v);
        checks++;
        if (v !== 32'd10) begin
            errors++;
            $display("FAIL count_lo: got %h expected 0000000a", v);
        end
        rd_reg(5'h10, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL ctrl_rd: got %h expected 00000001", v);
        end
        // Reserved word: writes ignored, reads zero.
        wr_reg(5'h18, 32'hDEAD_BEEF);
        rd_reg(5'h18, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL reserved_rd: got %h expected 00000000", v);
        end
    endtask

    task automatic test_carry();
        logic [31:0] lo, hi;
        do_reset();
        wr_reg(5'h00, 32'hFFFF_FFFE);
        wr_reg(5'h04, 32'h0);
        wr_reg(5'h10, 32'h1);
        idle(3);
        rd_reg(5'h00, lo);
        rd_reg(5'h04, hi);
        checks++;
        if (lo !== 32'h1) begin
            errors++;
            $display("FAIL carry_lo: got %h expected 00000001", lo);
        end
        checks++;
        if (hi !== 32'h1) begin
            errors++;
            $display("FAIL carry_hi: got %h expected 00000001", hi);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] lo, hi;
        do_reset();
        wr_reg(5'h00, 32'hFFFF_FFFF);
        wr_reg(5'h04, 32'hFFFF_FFFF);
        wr_reg(5'h10, 32'h1);
        idle(1);
        rd_reg(5'h00, lo);
        rd_reg(5'h04, hi);
        checks++;
        if (lo !== 32'h0) begin
            errors++;
            $display("FAIL wrap_lo: got %h expected 00000000", lo);
        end
        checks++;
        if (hi !== 32'h0) begin
            errors++;
            $display("FAIL wrap_hi: got %h expected 00000000", hi);
        end
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_irq: got %b expected 0", irq_o);
        end
    endtask

    task automatic test_write_collision();
        logic [31:0] lo, hi;
        do_reset();
        wr_reg(5'h00, 32'hFFFF_FFFF);
        wr_reg(5'h10, 32'h1);
        // Count enabled: this HI write must block the increment (and its carry).
        wr_reg(5'h04, 32'h5);
        rd_reg(5'h00, lo);
        rd_reg(5'h04, hi);
        checks++;
        if (lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL collide_lo: got %h expected ffffffff", lo);
        end
        checks++;
        if (hi !== 32'h5) begin
            errors++;
            $display("FAIL collide_hi: got %h expected 00000005", hi);
        end
    endtask

    task automatic test_irq();
        do_reset();
        wr_reg(5'h08, 32'h20);
        wr_reg(5'h0C, 32'h0);
        wr_reg(5'h10, 32'h3);
        // mtime reaches 0x20 on the 32nd counting edge.
        idle(32);
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_early: got %b expected 0", irq_o);
        end
        idle(1);
        checks++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL irq_rise: got %b expected 1", irq_o);
        end
        wr_reg(5'h08, 32'h100);
        checks++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL irq_hold: got %b expected 1", irq_o);
        end
        idle(1);
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_fall: got %b expected 0", irq_o);
        end
    endtask

    task automatic test_prescaler();
        logic [31:0] v, p;
        logic [31:0] exp_mt, exp_p;
`ifdef TIMER_PRESCALER_EN
        exp_mt = 32'd10;
        exp_p  = 32'd3;
`else
        exp_mt = 32'd40;
        exp_p  = 32'd0;
`endif
        do_reset();
        wr_reg(5'h14, 32'h3);
        wr_reg(5'h10, 32'h1);
        idle(40);
        rd_reg(5'h00, v);
        rd_reg(5'h14, p);
        checks++;
        if (v !== exp_mt) begin
            errors++;
            $display("FAIL presc_mtime: got %h expected %h", v, exp_mt);
        end
        checks++;
        if (p !== exp_p) begin
            errors++;
            $display("FAIL presc_reg: got %h expected %h", p, exp_p);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        addr        = '0;
        wdata       = '0;
        wr          = 1'b0;
        addr_strobe = 1'b0;
        @(negedge clk);
        test_reset();
        test_count();
        test_carry();
        test_wrap();
        test_write_collision();
        test_irq();
        test_prescaler();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
